// File: rtl/lane_pkg.sv
// Shared types and window indices for the lane detection pixel path.
// Holds the default pixel width, pixel/window typedefs and 3x3 index map.
package lane_pkg;

  localparam int PIX_W_DEFAULT = 8;

  typedef logic [PIX_W_DEFAULT-1:0] pixel_t;
  typedef pixel_t [8:0] window_t;

  // Element i = 3*y + x, y=0 top (oldest line), x=0 left (oldest column)
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_C  = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  function automatic int win_idx(input int y, input int x);
    return 3 * y + x;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One image line of pixel storage: sync write, async read-before-write.
// Ports: clk, we, waddr, wdata, raddr, rdata. Contents are not reset.
module line_ram
  import lane_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int W     = PIX_W_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read returns the pre-edge contents, so a read and
  // write to the same address in one cycle sees the old value.
  assign rdata = mem[raddr];

endmodule

// File: rtl/line_window_buffer.sv
// 3x3 neighbourhood generator over a raster pixel stream, two line RAMs.
// Ports: clk, rst_n, sof, pix_valid, pix_data -> win_valid, win_data, win_row, win_col, frame_done.
module line_window_buffer
  import lane_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = PIX_W_DEFAULT,
  localparam int CW        = $clog2(IMG_WIDTH),
  localparam int RW        = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             win_valid,
  output logic [9*PIX_W-1:0] win_data,
  output logic [RW-1:0]    win_row,
  output logic [CW-1:0]    win_col,
  output logic             frame_done
);

  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [RW-1:0] R_TWO  = RW'(2);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] cur_c;
  logic [RW-1:0] cur_r;
  logic [CW-1:0] nxt_c;
  logic [RW-1:0] nxt_r;
  logic          interior;
  logic          last_pix;

  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;
  logic [PIX_W-1:0] win_q [9];

  // sof overrides the tracked position for this very pixel
  always_comb begin
    cur_c = sof ? '0 : col_q;
    cur_r = sof ? '0 : row_q;
    nxt_c = cur_c + 1'b1;
    nxt_r = cur_r;
    if (cur_c == C_LAST) begin
      nxt_c = '0;
      nxt_r = (cur_r == R_LAST) ? '0 : cur_r + 1'b1;
    end
  end

  // Columns 0/1 still hold the previous line's tail in the window
  assign interior = (cur_r >= R_TWO) && (cur_c >= C_TWO);
  assign last_pix = (cur_r == R_LAST) && (cur_c == C_LAST);

  // lb1 = line r-1, lb0 = line r-2; lb1's old value ages into lb0
  line_ram #(
    .DEPTH (IMG_WIDTH),
    .W     (PIX_W)
  ) u_lb0 (
    .clk   (clk),
    .we    (pix_valid),
    .waddr (cur_c),
    .wdata (lb1_rd),
    .raddr (cur_c),
    .rdata (lb0_rd)
  );

  line_ram #(
    .DEPTH (IMG_WIDTH),
    .W     (PIX_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (pix_valid),
    .waddr (cur_c),
    .wdata (pix_data),
    .raddr (cur_c),
    .rdata (lb1_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      win_valid  <= pix_valid && interior;
      frame_done <= pix_valid && last_pix;
      if (pix_valid) begin
        col_q <= nxt_c;
        row_q <= nxt_r;
        for (int y = 0; y < 3; y++) begin
          win_q[win_idx(y, 0)] <= win_q[win_idx(y, 1)];
          win_q[win_idx(y, 1)] <= win_q[win_idx(y, 2)];
        end
        win_q[WIN_TR] <= lb0_rd;
        win_q[WIN_MR] <= lb1_rd;
        win_q[WIN_BR] <= pix_data;
        if (interior) begin
          win_row <= cur_r - 1'b1;
          win_col <= cur_c - 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < 9; i++) begin
      win_data[PIX_W*i +: PIX_W] = win_q[i];
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench for line_window_buffer on a 5x4 image.
// Image-array reference model; randomized valid gaps and data.
module tb_line_window_buffer;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int PW = 8;

  typedef logic [2+3+9*PW-1:0] wrec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sof;
  logic pix_valid;
  logic [PW-1:0] pix_data;
  logic win_valid;
  logic [9*PW-1:0] win_data;
  logic [1:0] win_row;
  logic [2:0] win_col;
  logic frame_done;

  int tests = 0;
  int fails = 0;

  logic [PW-1:0] img [H][W];
  int mr, mc;
  logic e_v, e_fd;
  logic [1:0] e_r;
  logic [2:0] e_c;
  logic [9*PW-1:0] e_d;
  wrec_t rec_ramp [$];

  line_window_buffer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIX_W      (PW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sof        (sof),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [9*PW-1:0] ramp_win(input int r0, input int c0,
                                               input int off);
    logic [9*PW-1:0] v;
    v = '0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        v[PW*(3*y+x) +: PW] = PW'(off + 10*(r0+y) + (c0+x));
    return v;
  endfunction

  // Drive one cycle, then derive expectations from the image model
  task automatic send(input logic s, input logic v, input logic [PW-1:0] d);
    sof = s;
    pix_valid = v;
    pix_data = d;
    @(posedge clk);
    #1;
    e_v = 1'b0;
    e_fd = 1'b0;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
        e_v = 1'b1;
        e_r = 2'(mr - 1);
        e_c = 3'(mc - 1);
        for (int y = 0; y < 3; y++)
          for (int x = 0; x < 3; x++)
            e_d[PW*(3*y+x) +: PW] = img[mr-2+y][mc-2+x];
      end
      e_fd = (mr == H-1) && (mc == W-1);
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr + 1) % H;
      end
    end
    sof = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sof = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mr = 0;
    mc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sof = 1'($urandom);
      pix_valid = 1'($urandom);
      pix_data = PW'($urandom);
      @(posedge clk);
      #1;
      tests++;
      if ({win_valid, frame_done, win_data, win_row, win_col} !== '0) begin
        fails++;
        $display("FAIL reset: got v=%b fd=%b d=%h r=%0d c=%0d want all 0",
                 win_valid, frame_done, win_data, win_row, win_col);
      end
    end
    do_reset();
  endtask

  task automatic test_ramp();
    int nwin = 0;
    int nfd = 0;
    rec_ramp.delete();
    do_reset();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(r == 0 && c == 0, 1'b1, PW'(10*r + c));
        tests++;
        if ({win_valid, frame_done} !== {e_v, e_fd}) begin
          fails++;
          $display("FAIL ramp_flags at (%0d,%0d): got %b%b want %b%b",
                   r, c, win_valid, frame_done, e_v, e_fd);
        end
        if (e_v) begin
          tests++;
          if ({win_row, win_col, win_data} !== {e_r, e_c, e_d}) begin
            fails++;
            $display("FAIL ramp_win: got %0d,%0d %h want %0d,%0d %h",
                     win_row, win_col, win_data, e_r, e_c, e_d);
          end
        end
        if (win_valid) begin
          rec_ramp.push_back({win_row, win_col, win_data});
          nwin++;
        end
        if (frame_done) begin
          nfd++;
          tests++;
          if ({win_valid, win_row, win_col} !== {1'b1, 2'd2, 3'd3}) begin
            fails++;
            $display("FAIL ramp_fd_coincide: got v=%b %0d,%0d want 1 2,3",
                     win_valid, win_row, win_col);
          end
        end
      end
    tests++;
    if (nwin != 6) begin
      fails++;
      $display("FAIL ramp_count: got %0d want 6", nwin);
    end
    tests++;
    if (rec_ramp[0] !== {2'd1, 3'd1, ramp_win(0, 0, 0)}) begin
      fails++;
      $display("FAIL ramp_first: got %h want %h", rec_ramp[0],
               {2'd1, 3'd1, ramp_win(0, 0, 0)});
    end
    tests++;
    if (rec_ramp[5] !== {2'd2, 3'd3, ramp_win(1, 2, 0)}) begin
      fails++;
      $display("FAIL ramp_last: got %h want %h", rec_ramp[5],
               {2'd2, 3'd3, ramp_win(1, 2, 0)});
    end
    tests++;
    if (nfd != 1) begin
      fails++;
      $display("FAIL ramp_fd_count: got %0d want 1", nfd);
    end
  endtask

  task automatic test_gaps();
    wrec_t got [$];
    do_reset();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        while ($urandom_range(1) == 1) begin
          send(1'($urandom), 1'b0, PW'($urandom));
          tests++;
          if ({win_valid, frame_done} !== 2'b00) begin
            fails++;
            $display("FAIL gaps_idle: got %b%b want 00",
                     win_valid, frame_done);
          end
        end
        send(r == 0 && c == 0, 1'b1, PW'(10*r + c));
        tests++;
        if ({win_valid, frame_done} !== {e_v, e_fd} ||
            (e_v && {win_row, win_col, win_data} !== {e_r, e_c, e_d})) begin
          fails++;
          $display("FAIL gaps_win: got %b%b %0d,%0d %h want %b%b %0d,%0d %h",
                   win_valid, frame_done, win_row, win_col, win_data,
                   e_v, e_fd, e_r, e_c, e_d);
        end
        if (win_valid) got.push_back({win_row, win_col, win_data});
      end
    tests++;
    if (got.size() != rec_ramp.size() || got != rec_ramp) begin
      fails++;
      $display("FAIL gaps_seq: got %0d windows, sequence differs from %0d",
               got.size(), rec_ramp.size());
    end
  endtask

  task automatic test_back_to_back();
    int nwin = 0;
    int nfd = 0;
    wrec_t first2;
    first2 = '0;
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          send(r == 0 && c == 0, 1'b1, PW'(50*f + 10*r + c));
          tests++;
          if ({win_valid, frame_done} !== {e_v, e_fd} ||
              (e_v && {win_row, win_col, win_data} !== {e_r, e_c, e_d})) begin
            fails++;
            $display("FAIL b2b_win: got %b%b %0d,%0d %h want %b%b %0d,%0d %h",
                     win_valid, frame_done, win_row, win_col, win_data,
                     e_v, e_fd, e_r, e_c, e_d);
          end
          if (win_valid) begin
            nwin++;
            if (nwin == 7) first2 = {win_row, win_col, win_data};
          end
          if (frame_done) nfd++;
        end
    tests++;
    if (nwin != 12 || nfd != 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d win %0d fd want 12 2", nwin, nfd);
    end
    tests++;
    if (first2 !== {2'd1, 3'd1, ramp_win(0, 0, 50)}) begin
      fails++;
      $display("FAIL b2b_first2: got %h want %h", first2,
               {2'd1, 3'd1, ramp_win(0, 0, 50)});
    end
  endtask

  task automatic test_sof_mid();
    int nwin = 0;
    wrec_t first;
    first = '0;
    do_reset();
    for (int i = 0; i < 8; i++)
      send(i == 0, 1'b1, PW'(10*(i / W) + (i % W)));
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(r == 0 && c == 0, 1'b1, PW'(100 + 10*r + c));
        tests++;
        if ({win_valid, frame_done} !== {e_v, e_fd} ||
            (e_v && {win_row, win_col, win_data} !== {e_r, e_c, e_d})) begin
          fails++;
          $display("FAIL sofmid_win: got %b%b %0d,%0d %h want %b%b %0d,%0d %h",
                   win_valid, frame_done, win_row, win_col, win_data,
                   e_v, e_fd, e_r, e_c, e_d);
        end
        if (win_valid) begin
          nwin++;
          if (nwin == 1) first = {win_row, win_col, win_data};
        end
      end
    tests++;
    if (nwin != 6 || first !== {2'd1, 3'd1, ramp_win(0, 0, 100)}) begin
      fails++;
      $display("FAIL sofmid_first: got %0d win %h want 6 %h", nwin, first,
               {2'd1, 3'd1, ramp_win(0, 0, 100)});
    end
  endtask

  task automatic test_rst_mid();
    wrec_t got [$];
    do_reset();
    for (int i = 0; i < 12; i++)
      send(i == 0, 1'b1, PW'($urandom));
    #2;
    rst_n = 1'b0;
    #2;
    tests++;
    if ({win_valid, frame_done, win_data, win_row, win_col} !== '0) begin
      fails++;
      $display("FAIL rstmid_zero: got v=%b fd=%b d=%h want 0",
               win_valid, frame_done, win_data);
    end
    rst_n = 1'b1;
    mr = 0;
    mc = 0;
    @(posedge clk);
    #1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(1'b0, 1'b1, PW'(10*r + c));
        if (win_valid) got.push_back({win_row, win_col, win_data});
        tests++;
        if ({win_valid, frame_done} !== {e_v, e_fd}) begin
          fails++;
          $display("FAIL rstmid_flags: got %b%b want %b%b",
                   win_valid, frame_done, e_v, e_fd);
        end
      end
    tests++;
    if (got.size() != rec_ramp.size() || got != rec_ramp) begin
      fails++;
      $display("FAIL rstmid_seq: got %0d windows, sequence differs from %0d",
               got.size(), rec_ramp.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < W*H; p++) begin
        while ($urandom_range(2) == 0) begin
          send(1'b0, 1'b0, PW'($urandom));
          tests++;
          if ({win_valid, frame_done} !== 2'b00) begin
            fails++;
            $display("FAIL rand_idle: got %b%b want 00",
                     win_valid, frame_done);
          end
        end
        send(p == 0, 1'b1, PW'($urandom));
        tests++;
        if ({win_valid, frame_done} !== {e_v, e_fd} ||
            (e_v && {win_row, win_col, win_data} !== {e_r, e_c, e_d})) begin
          fails++;
          $display("FAIL rand_win: got %b%b %0d,%0d %h want %b%b %0d,%0d %h",
                   win_valid, frame_done, win_row, win_col, win_data,
                   e_v, e_fd, e_r, e_c, e_d);
        end
      end
  endtask

  initial begin
    rst_n = 1'b0;
    sof = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    mr = 0;
    mc = 0;
    #1;
    test_reset();
    test_ramp();
    test_gaps();
    test_back_to_back();
    test_sof_mid();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
